// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps a combinational function through every input
// combination, captures its output per row, and compares the captured truth
// table against an expected minterm mask.
// Optional build macro: STOP_ON_FAIL_EN (end the scan at the first mismatch).
module truth_table_scanner #(
    parameter int N_VARS = 3,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [(1<<N_VARS)-1:0]  expected,
    output logic [N_VARS-1:0]       vars_out,
    input  logic                    f_in,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<N_VARS)-1:0]  table_out,
    output logic [N_VARS:0]         mismatch_count,
    output logic [N_VARS-1:0]       first_bad,
    output logic                    match
);
    localparam int W  = 1 << N_VARS;
    localparam int MW = N_VARS + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t              state_reg;
    logic [N_VARS-1:0]   row_reg;
    logic [CW-1:0]       cnt_reg;
    logic [W-1:0]        exp_reg;
    logic [N_VARS-1:0]   vars_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [W-1:0]        table_reg;
    logic [MW-1:0]       mis_reg;
    logic [N_VARS-1:0]   first_bad_reg;
    logic                match_reg;

    logic [W-1:0]        row_hit;
    logic                exp_bit;
    logic                sample_now;
    logic                row_bad;
    logic                last_row;
    logic                stop_now;

    // One-hot decode of the current row, used to pick the expected bit.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_row_hit
            assign row_hit[gi] = (row_reg == N_VARS'(gi));
        end
    endgenerate

    assign exp_bit    = |(row_hit & exp_reg);
    assign sample_now = (cnt_reg == CW'(SETTLE - 1));
    // Case inequality so an X/Z on the function output counts as a mismatch.
    assign row_bad    = (f_in !== exp_bit);
    assign last_row   = (row_reg == N_VARS'(W - 1));

`ifdef STOP_ON_FAIL_EN
    assign stop_now = row_bad;
`else
    assign stop_now = 1'b0;
`endif

    // Scan FSM: walks rows, holds each for SETTLE cycles, samples on the last.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            cnt_reg       <= '0;
            exp_reg       <= '0;
            vars_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            table_reg     <= '0;
            mis_reg       <= '0;
            first_bad_reg <= '0;
            match_reg     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    vars_reg <= '0;
                    if (start) begin
                        exp_reg       <= expected;
                        table_reg     <= '0;
                        mis_reg       <= '0;
                        first_bad_reg <= '0;
                        match_reg     <= 1'b1;
                        row_reg       <= '0;
                        cnt_reg       <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (sample_now) begin
                        table_reg[row_reg] <= f_in;
                        cnt_reg            <= '0;
                        if (row_bad) begin
                            mis_reg   <= mis_reg + MW'(1);
                            match_reg <= 1'b0;
                            if (mis_reg == '0)
                                first_bad_reg <= row_reg;
                        end
                        if (last_row || stop_now) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            vars_reg  <= '0;
                        end else begin
                            row_reg  <= row_reg + N_VARS'(1);
                            vars_reg <= row_reg + N_VARS'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign vars_out       = vars_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign table_out      = table_reg;
    assign mismatch_count = mis_reg;
    assign first_bad      = first_bad_reg;
    assign match          = match_reg;

endmodule
